// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with blanking gaps and frame-synchronous,
// double-buffered digit/dot data. Define DISP_BRIGHTNESS_EN to add the frame-based brightness input.
module disp_scan_ctrl #(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dots_in,
`ifdef DISP_BRIGHTNESS_EN
  input  logic [2:0]  brightness,
`endif
  output logic [1:0]  dig_sel,
  output logic [3:0]  nibble,
  output logic [3:0]  dots,
  output logic [3:0]  anodes,
  output logic        frame_tick,
  output logic        busy
);

  // state | meaning
  // IDLE  | scan parked, display dark, pending staging commits every cycle
  // BLANK | first BLANK_CYCLES of a slot, all anodes off
  // DRIVE | rest of the slot, anode of dig_sel on (if lit this frame)
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] SLOT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] TICK_PREV = CW'(PRESCALE - 2);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic          frame_tick_q, frame_tick_d;
  logic          busy_q, busy_d;
  logic [15:0]   stage_dig_q, stage_dig_d, act_dig_q, act_dig_d;
  logic [3:0]    stage_dots_q, stage_dots_d, act_dots_q, act_dots_d;
  logic [3:0]    nibble_q, nibble_d, dots_q, dots_d, anodes_q, anodes_d;
  logic          commit, lit;
`ifdef DISP_BRIGHTNESS_EN
  logic [2:0]    frame_cnt_q, frame_cnt_d, bright_q, bright_d;
  logic          frame_start;
`endif

  always_comb begin
    // Commit at the last digit-3 drive cycle; while parked, staging always flows through.
    commit       = frame_tick_q || (state_q == IDLE);
    stage_dig_d  = load ? digits_in : stage_dig_q;
    stage_dots_d = load ? dots_in : stage_dots_q;
    act_dig_d    = act_dig_q;
    act_dots_d   = act_dots_q;
    busy_d       = busy_q;
    if (commit) begin
      act_dig_d  = load ? digits_in : stage_dig_q;
      act_dots_d = load ? dots_in : stage_dots_q;
      busy_d     = 1'b0;
    end else if (load) begin
      busy_d = 1'b1;
    end

    state_d      = state_q;
    cnt_d        = cnt_q;
    dig_d        = dig_q;
    frame_tick_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      dig_d   = 2'd0;
    end else if (state_q == IDLE) begin
      state_d = BLANK;
      cnt_d   = '0;
      dig_d   = 2'd0;
    end else begin
      if (cnt_q == SLOT_LAST) begin
        cnt_d = '0;
        dig_d = dig_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      state_d      = (cnt_d < BLANK_END) ? BLANK : DRIVE;
      frame_tick_d = (cnt_q == TICK_PREV) && (dig_q == 2'd3);
    end

`ifdef DISP_BRIGHTNESS_EN
    frame_start = (state_d == BLANK) && (cnt_d == '0) && (dig_d == 2'd0);
    frame_cnt_d = !enable ? 3'd0 : (frame_tick_q ? frame_cnt_q + 3'd1 : frame_cnt_q);
    bright_d    = frame_start ? brightness : bright_q;
    lit         = (frame_cnt_d <= bright_d);
`else
    lit         = 1'b1;
`endif

    anodes_d = ((state_d == DRIVE) && lit) ? ~(4'b0001 << dig_d) : 4'b1111;
    nibble_d = act_dig_d[{dig_d, 2'b00} +: 4];
    dots_d   = act_dots_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dig_q        <= 2'd0;
      frame_tick_q <= 1'b0;
      busy_q       <= 1'b0;
      stage_dig_q  <= 16'h0;
      stage_dots_q <= 4'h0;
      act_dig_q    <= 16'h0;
      act_dots_q   <= 4'h0;
      nibble_q     <= 4'h0;
      dots_q       <= 4'h0;
      anodes_q     <= 4'b1111;
`ifdef DISP_BRIGHTNESS_EN
      frame_cnt_q  <= 3'd0;
      bright_q     <= 3'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      frame_tick_q <= frame_tick_d;
      busy_q       <= busy_d;
      stage_dig_q  <= stage_dig_d;
      stage_dots_q <= stage_dots_d;
      act_dig_q    <= act_dig_d;
      act_dots_q   <= act_dots_d;
      nibble_q     <= nibble_d;
      dots_q       <= dots_d;
      anodes_q     <= anodes_d;
`ifdef DISP_BRIGHTNESS_EN
      frame_cnt_q  <= frame_cnt_d;
      bright_q     <= bright_d;
`endif
    end
  end

  assign dig_sel    = dig_q;
  assign nibble     = nibble_q;
  assign dots       = dots_q;
  assign anodes     = anodes_q;
  assign frame_tick = frame_tick_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: a time-based model of the scan and the load/commit rules, compared every
// cycle, plus directed scenarios with literal expectations. Brightness checks need DISP_BRIGHTNESS_EN.
module tb_disp_scan_ctrl;
  localparam int P = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dots_in = 4'h0;
  logic [2:0]  brightness = 3'd7;
  logic [1:0]  dig_sel;
  logic [3:0]  nibble, dots, anodes;
  logic        frame_tick, busy;

  int n_cmp = 0;
  int n_fail = 0;

  disp_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .digits_in(digits_in), .dots_in(dots_in),
`ifdef DISP_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .dig_sel(dig_sel), .nibble(nibble), .dots(dots), .anodes(anodes),
    .frame_tick(frame_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: m_t counts cycles since the scan left IDLE; everything visible derives from it.
  int          m_t = 0;
  bit          m_run = 0;
  int          m_dig = 0, m_pos = 0, m_frame = 0;
  bit          m_ft = 0, m_busy = 0, m_lit = 1;
  logic [3:0]  m_an = 4'hF, m_dots = 4'h0, m_nib = 4'h0, m_stage_dots = 4'h0, m_act_dots = 4'h0;
  logic [15:0] m_stage_dig = 16'h0, m_act_dig = 16'h0;
  int          m_bright = 7;
  bit          m_commit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_run = 0; m_dig = 0; m_pos = 0; m_frame = 0; m_ft = 0; m_busy = 0;
      m_an = 4'hF; m_dots = 4'h0; m_nib = 4'h0; m_stage_dig = 16'h0; m_stage_dots = 4'h0;
      m_act_dig = 16'h0; m_act_dots = 4'h0;
    end else begin
      m_commit = m_ft || !m_run;
      if (m_commit) begin
        m_act_dig  = load ? digits_in : m_stage_dig;
        m_act_dots = load ? dots_in : m_stage_dots;
        m_busy     = 0;
      end else if (load) begin
        m_busy = 1;
      end
      if (load) begin
        m_stage_dig  = digits_in;
        m_stage_dots = dots_in;
      end
      if (!enable) begin
        m_run = 0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1; m_t = 0;
      end else begin
        m_t++;
      end
      if (m_run) begin
        m_dig   = (m_t / P) % 4;
        m_pos   = m_t % P;
        m_frame = m_t / (4 * P);
`ifdef DISP_BRIGHTNESS_EN
        if (m_dig == 0 && m_pos == 0) m_bright = int'(brightness);
`endif
        m_lit = ((m_frame % 8) <= m_bright);
        m_ft  = (m_dig == 3) && (m_pos == P - 1);
        m_an  = (m_pos >= B && m_lit) ? ~(4'b0001 << m_dig) : 4'hF;
      end else begin
        m_dig = 0; m_pos = 0; m_ft = 0; m_an = 4'hF;
      end
      m_nib  = 4'((m_act_dig >> (4 * m_dig)) & 16'hF);
      m_dots = m_act_dots;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("anodes", 32'(anodes), 32'(m_an));
    chk("dig_sel", 32'(dig_sel), 32'(m_dig));
    chk("nibble", 32'(nibble), 32'(m_nib));
    chk("dots", 32'(dots), 32'(m_dots));
    chk("frame_tick", 32'(frame_tick), 32'(m_ft));
    chk("busy", 32'(busy), 32'(m_busy));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until the current displayed cycle is slot position p of digit d.
  task automatic wait_until(input int d, input int p);
    int guard = 0;
    while (!(m_run && m_dig == d && m_pos == p) && guard < 200) begin
      tick(1);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_until: digit %0d pos %0d not reached", d, p);
    end
  endtask

  task automatic do_load(input logic [15:0] dg, input logic [3:0] dt);
    digits_in = dg; dots_in = dt; load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  logic [3:0] slot_an [4];
  int lit_frames;
  bit frame_lit [8];

  initial begin
    slot_an[0] = 4'b1110; slot_an[1] = 4'b1101; slot_an[2] = 4'b1011; slot_an[3] = 4'b0111;
    tick(3);
    chk("reset_anodes", 32'(anodes), 32'hF);
    chk("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // 1: full frame of anode pattern
    enable = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("t1_anodes", 32'(anodes), 32'((i % 8) < 2 ? 4'hF : slot_an[i / 8]));
      chk("t1_dig_sel", 32'(dig_sel), 32'(i / 8));
      chk("t1_frame_tick", 32'(frame_tick), 32'(i == 31));
    end
    @(negedge clk);
    chk("t1_wrap_dig", 32'(dig_sel), 32'h0);

    // 2: load mid-frame, visible next frame
    wait_until(1, 4);
    do_load(16'hA5C3, 4'b0101);
    chk("t2_busy_set", 32'(busy), 32'h1);
    wait_until(2, 4);
    chk("t2_old_nibble", 32'(nibble), 32'h0);
    chk("t2_old_dots", 32'(dots), 32'h0);
    wait_until(3, 7);
    chk("t2_busy_at_tick", 32'(busy), 32'h1);
    tick(1);
    chk("t2_busy_clr", 32'(busy), 32'h0);
    chk("t2_nib0", 32'(nibble), 32'h3);
    chk("t2_dots", 32'(dots), 32'h5);
    wait_until(1, 3); chk("t2_nib1", 32'(nibble), 32'hC);
    wait_until(2, 3); chk("t2_nib2", 32'(nibble), 32'h5);
    wait_until(3, 3); chk("t2_nib3", 32'(nibble), 32'hA);

    // 3: last load wins
    wait_until(1, 4);
    do_load(16'h1111, 4'b0011);
    tick(1);
    do_load(16'h2222, 4'b1100);
    for (int d = 0; d < 4; d++) begin
      wait_until(d, 3);
      chk("t3_nibble", 32'(nibble), 32'h2);
    end
    chk("t3_dots", 32'(dots), 32'hC);

    // 4: load on the commit cycle goes straight through
    wait_until(3, 7);
    chk("t4_tick", 32'(frame_tick), 32'h1);
    do_load(16'hBEEF, 4'b1010);
    chk("t4_busy", 32'(busy), 32'h0);
    wait_until(0, 2);
    chk("t4_nibble", 32'(nibble), 32'hF);
    chk("t4_anodes", 32'(anodes), 32'hE);

    // 5: disable during digit 2 drive, then restart
    wait_until(2, 4);
    enable = 1'b0;
    tick(1);
    chk("t5_anodes_off", 32'(anodes), 32'hF);
    chk("t5_dig_sel", 32'(dig_sel), 32'h0);
    chk("t5_no_tick", 32'(frame_tick), 32'h0);
    tick(3);
    enable = 1'b1;
    tick(1); chk("t5_blank0", 32'(anodes), 32'hF);
    tick(1); chk("t5_blank1", 32'(anodes), 32'hF);
    tick(1); chk("t5_drive", 32'(anodes), 32'hE);

    // 6: asynchronous reset mid-drive
    wait_until(1, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_anodes", 32'(anodes), 32'hF);
    chk("t6_rst_dig", 32'(dig_sel), 32'h0);
    chk("t6_rst_nibble", 32'(nibble), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    brightness = 3'd1;
    tick(2);
    rst_n = 1'b1;

`ifdef DISP_BRIGHTNESS_EN
    wait_until(0, 0);
    lit_frames = 0;
    for (int f = 0; f < 8; f++) begin
      frame_lit[f] = 0;
      for (int c = 0; c < 32; c++) begin
        if (anodes != 4'hF) frame_lit[f] = 1;
        tick(1);
      end
      if (frame_lit[f]) lit_frames++;
    end
    chk("t6_lit_frames", 32'(lit_frames), 32'd2);
    chk("t6_frame0_lit", 32'(frame_lit[0]), 32'h1);
    chk("t6_frame1_lit", 32'(frame_lit[1]), 32'h1);
    chk("t6_frame2_dark", 32'(frame_lit[2]), 32'h0);
`endif

    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
